// File: rtl/led_sequencer.sv
// led_sequencer: colour-code stepper, hold-to-run or per-press.
// Define LEDSEQ_BOUNCE_EN for ping-pong instead of wrap-around.
module led_sequencer #(
  parameter int WIDTH    = 3,
  parameter int FIRST    = 1,
  parameter int LAST     = 6,
  parameter int STEP_DIV = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             button,
  input  logic             dir,
  input  logic             mode,
  output logic [WIDTH-1:0] colour,
  output logic             step,
  output logic             wrap
);

  localparam int CW =
    (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [WIDTH-1:0] LO = WIDTH'(FIRST);
  localparam logic [WIDTH-1:0] HI = WIDTH'(LAST);
  localparam logic [CW-1:0] CMAX = CW'(STEP_DIV - 1);

  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             btn_q;
  logic             rev;
  logic             illegal;
  logic             fire;
  logic             down;
  logic [WIDTH-1:0] adv;
  logic             adv_wrap;
`ifdef LEDSEQ_BOUNCE_EN
  logic             adv_flip;
`endif

  // code outside FIRST..LAST forces a recovery cycle
  assign illegal = (colour < LO) || (colour > HI);

  assign down = dir ^ rev;

  // step trigger: rate counter in hold mode, edge in press mode
  always_comb begin
    fire    = 1'b0;
    cnt_nxt = '0;
    if (mode) begin
      fire = button & ~btn_q;
    end else if (button) begin
      if (cnt == CMAX) begin
        fire = 1'b1;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end
  end

  // next code for a step in the effective direction
  always_comb begin
    adv      = colour;
    adv_wrap = 1'b0;
`ifdef LEDSEQ_BOUNCE_EN
    adv_flip = 1'b0;
`endif
    unique case (1'b1)
      (!down && colour == HI): begin
        adv_wrap = 1'b1;
`ifdef LEDSEQ_BOUNCE_EN
        adv      = HI - WIDTH'(1);
        adv_flip = 1'b1;
`else
        adv      = LO;
`endif
      end
      (!down && colour != HI): begin
        adv = colour + WIDTH'(1);
      end
      (down && colour == LO): begin
        adv_wrap = 1'b1;
`ifdef LEDSEQ_BOUNCE_EN
        adv      = LO + WIDTH'(1);
        adv_flip = 1'b1;
`else
        adv      = HI;
`endif
      end
      (down && colour != LO): begin
        adv = colour - WIDTH'(1);
      end
      default: begin
        adv = colour;
      end
    endcase
  end

`ifdef LEDSEQ_BOUNCE_EN
  // direction flag flips at each turnaround
  always_ff @(posedge clk) begin
    if (rst) begin
      rev <= 1'b0;
    end else if (illegal) begin
      rev <= 1'b0;
    end else if (fire) begin
      rev <= rev ^ adv_flip;
    end
  end
`else
  assign rev = 1'b0;
`endif

  // registered colour, counter and status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      colour <= LO;
      step   <= 1'b0;
      wrap   <= 1'b0;
      cnt    <= '0;
      btn_q  <= 1'b0;
    end else begin
      btn_q <= button;
      if (illegal) begin
        colour <= LO;
        cnt    <= '0;
        step   <= 1'b0;
        wrap   <= 1'b0;
      end else begin
        cnt  <= cnt_nxt;
        step <= fire;
        wrap <= fire & adv_wrap;
        if (fire) begin
          colour <= adv;
        end
      end
    end
  end

endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: vector table for the default instance,
// hand sequences for the divided-rate and illegal-code cases.
module tb_led_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       button = 1'b0;
  logic       dir = 1'b0;
  logic       mode = 1'b0;
  logic [2:0] colour;
  logic       step;
  logic       wrap;

  logic       rst4 = 1'b1;
  logic       b4 = 1'b0;
  logic [2:0] c4;
  logic       s4;
  logic       w4;

  led_sequencer u_dut (
    .clk(clk),
    .rst(rst),
    .button(button),
    .dir(dir),
    .mode(mode),
    .colour(colour),
    .step(step),
    .wrap(wrap)
  );

  led_sequencer #(.STEP_DIV(4)) u_div4 (
    .clk(clk),
    .rst(rst4),
    .button(b4),
    .dir(1'b0),
    .mode(1'b0),
    .colour(c4),
    .step(s4),
    .wrap(w4)
  );

  typedef struct {
    logic       r;
    logic       b;
    logic       d;
    logic       m;
    logic [2:0] c;
    logic       s;
    logic       w;
  } vec_t;

  vec_t vq[$];
  int errors = 0;
  int checks = 0;

  function automatic void add(logic r, logic b, logic d,
                              logic m, int c, logic s,
                              logic w);
    vec_t v;
    v.r = r;
    v.b = b;
    v.d = d;
    v.m = m;
    v.c = 3'(c);
    v.s = s;
    v.w = w;
    vq.push_back(v);
  endfunction

  task automatic chk(string name,
                     logic [2:0] ac, logic as, logic aw,
                     logic [2:0] ec, logic es, logic ew);
    checks++;
    if ({ac, as, aw} !== {ec, es, ew}) begin
      errors++;
      $display("FAIL %s: got colour=%0d step=%0b wrap=%0b, need colour=%0d step=%0b wrap=%0b",
               name, ac, as, aw, ec, es, ew);
    end
  endtask

  task automatic tick4(logic r, logic b, int ec,
                       logic es, string name);
    @(negedge clk);
    rst4 = r;
    b4   = b;
    @(posedge clk);
    #1;
    chk(name, c4, s4, w4, 3'(ec), es, 1'b0);
  endtask

  initial begin
    int p;
`ifndef LEDSEQ_BOUNCE_EN
    int hold_exp[8] = '{2, 3, 4, 5, 6, 1, 2, 3};
    int press_exp[3] = '{6, 5, 4};
`else
    int bnc_exp[11] = '{2, 3, 4, 5, 6, 5, 4, 3, 2, 1, 2};
`endif

    add(1, 0, 0, 0, 1, 0, 0);
`ifndef LEDSEQ_BOUNCE_EN
    foreach (hold_exp[i])
      add(0, 1, 0, 0, hold_exp[i], 1, hold_exp[i] == 1);
    add(0, 0, 0, 0, 3, 0, 0);
    add(0, 0, 0, 0, 3, 0, 0);
    add(0, 1, 0, 0, 4, 1, 0);
    add(0, 1, 0, 1, 4, 0, 0);
    add(0, 1, 0, 1, 4, 0, 0);
    add(0, 0, 0, 1, 4, 0, 0);
    add(0, 1, 0, 1, 5, 1, 0);
    add(0, 1, 0, 0, 6, 1, 0);
    add(0, 0, 0, 0, 6, 0, 0);
    add(1, 0, 1, 1, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      add(0, 1, 1, 1, press_exp[k], 1, k == 0);
      for (int j = 0; j < 4; j++)
        add(0, 1, 1, 1, press_exp[k], 0, 0);
      add(0, 0, 1, 1, press_exp[k], 0, 0);
      add(0, 0, 1, 1, press_exp[k], 0, 0);
    end
    add(0, 1, 0, 0, 5, 1, 0);
    add(0, 1, 1, 0, 4, 1, 0);
    add(0, 1, 1, 0, 3, 1, 0);
    add(0, 1, 0, 0, 4, 1, 0);
    add(1, 0, 1, 0, 1, 0, 0);
    add(0, 1, 1, 0, 6, 1, 1);
    add(0, 1, 1, 0, 5, 1, 0);
    add(1, 0, 0, 0, 1, 0, 0);
    for (int k = 2; k <= 5; k++)
      add(0, 1, 0, 0, k, 1, 0);
    add(1, 1, 0, 0, 1, 0, 0);
    add(0, 1, 0, 0, 2, 1, 0);
`else
    foreach (bnc_exp[i])
      add(0, 1, 0, 0, bnc_exp[i], 1, i == 5 || i == 10);
    add(0, 0, 0, 0, 2, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0);
    add(0, 1, 0, 0, 2, 1, 0);
`endif

    p = 0;
    foreach (vq[i]) begin
      @(negedge clk);
      rst    = vq[i].r;
      button = vq[i].b;
      dir    = vq[i].d;
      mode   = vq[i].m;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", p), colour, step, wrap,
          vq[i].c, vq[i].s, vq[i].w);
      p++;
    end

    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      rst    = 1'b0;
      button = 1'b1;
      dir    = 1'b0;
      mode   = 1'b0;
      force u_dut.colour = (k == 0) ? 3'd7 : 3'd0;
      #1;
      release u_dut.colour;
      @(posedge clk);
      #1;
      chk("illegal_recover", colour, step, wrap,
          3'd1, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      chk("illegal_resume", colour, step, wrap,
          3'd2, 1'b1, 1'b0);
    end

    tick4(1, 0, 1, 0, "div4_reset");
    for (int k = 1; k <= 12; k++)
      tick4(0, 1, 1 + k / 4, (k % 4) == 0,
            $sformatf("div4_hold%0d", k));
    tick4(1, 0, 1, 0, "div4_reset2");
    for (int k = 1; k <= 6; k++)
      tick4(0, 1, (k >= 4) ? 2 : 1, k == 4,
            $sformatf("div4_part%0d", k));
    tick4(0, 0, 2, 0, "div4_release");
    for (int k = 1; k <= 4; k++)
      tick4(0, 1, (k == 4) ? 3 : 2, k == 4,
            $sformatf("div4_repress%0d", k));
    tick4(0, 1, 3, 0, "div4_mid1");
    tick4(0, 1, 3, 0, "div4_mid2");
    tick4(1, 1, 1, 0, "div4_rst_mid");
    for (int k = 1; k <= 4; k++)
      tick4(0, 1, (k == 4) ? 2 : 1, k == 4,
            $sformatf("div4_after_rst%0d", k));

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
